// File: rtl/gated_photon_binner.sv
// Time-gated PMT edge binner: counts detected PMT edges into NBINS bins after each SYNC edge,
// accumulates over max_count SYNC periods, then streams the bin totals over valid/ready.
module gated_photon_binner #(
  parameter int NBINS = 40,
  parameter int CW    = 16
) (
  input  logic          clk_in,
  input  logic          reset_n,
  input  logic          pmt_in,
  input  logic          sync_in,
  input  logic          enable,
  input  logic [31:0]   bin_div,
  input  logic [16:0]   max_count,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [CW-1:0] rd_data,
  output logic [5:0]    rd_bin,
  output logic          rd_last,
  output logic          busy,
  output logic          overflow
);
  localparam int IW = $clog2(NBINS);
  localparam logic [IW-1:0] LAST = IW'(NBINS - 1);

  typedef enum logic [1:0] {IDLE, ARM, BIN, DUMP} state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  logic [2:0]    pmt_sync_q, sync_sync_q;
  logic          pmt_e, sync_e;
  state_t        state_q;
  logic          busy_q, done_q, overflow_q;
  logic [31:0]   bin_div_q, timer_q;
  logic [16:0]   max_q, period_q;
  logic [IW-1:0] bin_idx_q, rd_idx_q;
  logic [CW-1:0] acc_q [NBINS];
  logic          rd_valid_q, rd_last_q;
  logic [CW-1:0] rd_data_q;

  logic [31:0]   bin_div_eff;
  logic [16:0]   max_eff;
  logic          wrap;
  logic [IW-1:0] rd_nxt;
  logic          acc_inc, acc_clr;
  logic [IW-1:0] acc_idx;

  // Identical synchronizer depth on both inputs keeps PMT/SYNC alignment exact.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      pmt_sync_q  <= '0;
      sync_sync_q <= '0;
    end else begin
      pmt_sync_q  <= {pmt_sync_q[1:0], pmt_in};
      sync_sync_q <= {sync_sync_q[1:0], sync_in};
    end
  end

  assign pmt_e       = pmt_sync_q[1] & ~pmt_sync_q[2];
  assign sync_e      = sync_sync_q[1] & ~sync_sync_q[2];
  assign bin_div_eff = (bin_div == '0) ? 32'd1 : bin_div;
  assign max_eff     = (max_count == '0) ? 17'd1 : max_count;
  assign wrap        = (timer_q == bin_div_q - 32'd1);
  assign rd_nxt      = rd_idx_q + IW'(1);

  always_comb begin
    acc_inc = 1'b0;
    acc_idx = bin_idx_q;
    acc_clr = 1'b0;
    if (enable && pmt_e) begin
      if (state_q == ARM && sync_e) begin
        acc_inc = 1'b1;
        acc_idx = '0;
      end else if (state_q == BIN) begin
        if (sync_e) begin
          acc_inc = (period_q < max_q);
          acc_idx = '0;
        end else begin
          acc_inc = !done_q;
        end
      end
    end
    if (!enable && (state_q == ARM || state_q == BIN)) acc_clr = 1'b1;
    if (state_q == DUMP && rd_ready && rd_last_q) acc_clr = 1'b1;
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      bin_div_q  <= 32'd1;
      timer_q    <= '0;
      max_q      <= 17'd1;
      period_q   <= '0;
      bin_idx_q  <= '0;
      rd_idx_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
      for (int i = 0; i < NBINS; i++) acc_q[i] <= '0;
    end else begin
      if (acc_inc) begin
        acc_q[acc_idx] <= sat_inc(acc_q[acc_idx]);
        if (&acc_q[acc_idx]) overflow_q <= 1'b1;
      end
      if (acc_clr) begin
        for (int i = 0; i < NBINS; i++) acc_q[i] <= '0;
        overflow_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q   <= ARM;
            busy_q    <= 1'b1;
            bin_div_q <= bin_div_eff;
            max_q     <= max_eff;
          end
        end
        ARM: begin
          if (!enable) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (sync_e) begin
            state_q   <= BIN;
            bin_idx_q <= '0;
            timer_q   <= '0;
            period_q  <= 17'd1;
            done_q    <= 1'b0;
          end
        end
        BIN: begin
          if (!enable) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (sync_e) begin
            if (period_q < max_q) begin
              period_q  <= period_q + 17'd1;
              bin_idx_q <= '0;
              timer_q   <= '0;
              done_q    <= 1'b0;
            end else begin
              state_q    <= DUMP;
              rd_valid_q <= 1'b1;
              rd_idx_q   <= '0;
              rd_data_q  <= acc_q[0];
              rd_last_q  <= 1'b0;
            end
          end else if (!done_q) begin
            // Past the last bin the timer freezes until the next SYNC.
            if (wrap) begin
              timer_q <= '0;
              if (bin_idx_q == LAST) done_q <= 1'b1;
              else bin_idx_q <= bin_idx_q + IW'(1);
            end else begin
              timer_q <= timer_q + 32'd1;
            end
          end
        end
        DUMP: begin
          if (rd_ready) begin
            if (rd_last_q) begin
              rd_valid_q <= 1'b0;
              rd_data_q  <= '0;
              rd_idx_q   <= '0;
              rd_last_q  <= 1'b0;
              if (enable) begin
                state_q   <= ARM;
                bin_div_q <= bin_div_eff;
                max_q     <= max_eff;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              rd_idx_q  <= rd_nxt;
              rd_data_q <= acc_q[rd_nxt];
              rd_last_q <= (rd_nxt == LAST);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_bin   = 6'(rd_idx_q);
  assign rd_last  = rd_last_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_gated_photon_binner.sv
// Bench for gated_photon_binner: scripted and random runs scored against a bin-arithmetic model.
module tb_gated_photon_binner;
  localparam int NBINS = 4;
  localparam int CW    = 4;
  localparam int MAXV  = 15;
  localparam int MAXL  = 1024;

  logic          clk_in = 1'b0;
  logic          reset_n, pmt_in, sync_in, enable, rd_ready;
  logic [31:0]   bin_div;
  logic [16:0]   max_count;
  logic          rd_valid, rd_last, busy, overflow;
  logic [CW-1:0] rd_data;
  logic [5:0]    rd_bin;

  int n_cmp = 0;
  int n_err = 0;
  bit sbit [MAXL];
  bit pbit [MAXL];
  int run_len;
  int exp_bins [NBINS];
  bit exp_ovf;

  gated_photon_binner #(.NBINS(NBINS), .CW(CW)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .pmt_in(pmt_in), .sync_in(sync_in),
    .enable(enable), .bin_div(bin_div), .max_count(max_count),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_bin(rd_bin),
    .rd_last(rd_last), .busy(busy), .overflow(overflow)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < MAXL; i++) begin
      sbit[i] = 1'b0;
      pbit[i] = 1'b0;
    end
  endtask

  // Reference: each PMT edge lands in the period opened by the latest SYNC at or before it;
  // offset 0 is bin 0, offset d>0 is bin (d-1)/bin_div; the final SYNC opens no period.
  task automatic model(input int bd_in);
    int st[$];
    int bd, last_s, j, d, b;
    bd = (bd_in == 0) ? 1 : bd_in;
    for (int c = 0; c < run_len; c++) if (sbit[c]) st.push_back(c);
    for (int k = 0; k < NBINS; k++) exp_bins[k] = 0;
    exp_ovf = 1'b0;
    if (st.size() < 2) return;
    last_s = st[st.size()-1];
    for (int c = 0; c < last_s; c++) begin
      if (!pbit[c]) continue;
      j = -1;
      for (int i = 0; i < st.size() - 1; i++) if (st[i] <= c) j = i;
      if (j < 0) continue;
      d = c - st[j];
      b = (d == 0) ? 0 : (d - 1) / bd;
      if (b < NBINS) begin
        if (exp_bins[b] == MAXV) exp_ovf = 1'b1;
        else exp_bins[b]++;
      end
    end
  endtask

  task automatic start_run(input int bd, input int mc);
    bin_div   = 32'(bd);
    max_count = 17'(mc);
    enable    = 1'b1;
    repeat (4) tick();
  endtask

  task automatic drive_run();
    for (int c = 0; c < run_len; c++) begin
      sync_in = sbit[c];
      pmt_in  = pbit[c];
      tick();
    end
    sync_in = 1'b0;
    pmt_in  = 1'b0;
  endtask

  task automatic do_dump(input bit rand_ready, input bit noise);
    int waitc, beat, cycles;
    bit prev_stall;
    logic [CW-1:0] pd;
    logic [5:0] pb;
    logic pl;
    waitc = 0; beat = 0; cycles = 0; prev_stall = 1'b0;
    pd = '0; pb = '0; pl = 1'b0;
    check_eq("busy_run", busy, 1);
    while (!rd_valid && waitc < 100) begin
      tick();
      waitc++;
    end
    check_eq("dump_start", rd_valid, 1);
    if (!rd_valid) return;
    check_eq("ovf_at_dump", overflow, exp_ovf);
    enable = 1'b0;
    while (beat < NBINS && cycles < 300) begin
      check_eq("valid_hold", rd_valid, 1);
      if (prev_stall) begin
        check_eq("stall_data", rd_data, pd);
        check_eq("stall_bin", rd_bin, pb);
        check_eq("stall_last", rd_last, pl);
      end
      rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (noise) begin
        sync_in = 1'($urandom_range(0, 1));
        pmt_in  = 1'($urandom_range(0, 1));
      end
      if (rd_valid && rd_ready) begin
        check_eq("beat_bin", rd_bin, beat);
        check_eq("beat_data", rd_data, exp_bins[beat]);
        check_eq("beat_last", rd_last, (beat == NBINS - 1));
        beat++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = rd_valid;
      end
      pd = rd_data;
      pb = rd_bin;
      pl = rd_last;
      tick();
      cycles++;
    end
    check_eq("beat_count", beat, NBINS);
    rd_ready = 1'b0;
    sync_in  = 1'b0;
    pmt_in   = 1'b0;
    check_eq("valid_after", rd_valid, 0);
    check_eq("busy_after", busy, 0);
    check_eq("ovf_after", overflow, 0);
    repeat (4) tick();
  endtask

  task automatic run_case(input int bd, input int mc, input bit rr, input bit noise);
    start_run(bd, mc);
    drive_run();
    model(bd);
    do_dump(rr, noise);
  endtask

  initial begin
    int waitc;
    reset_n = 1'b0; pmt_in = 1'b0; sync_in = 1'b0; enable = 1'b0; rd_ready = 1'b0;
    bin_div = 32'd1; max_count = 17'd1;
    repeat (3) tick();
    check_eq("rst_valid", rd_valid, 0);
    check_eq("rst_data", rd_data, 0);
    check_eq("rst_bin", rd_bin, 0);
    check_eq("rst_last", rd_last, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ovf", overflow, 0);
    #2 reset_n = 1'b1;
    repeat (2) tick();

    // Basic binning
    clear_stim();
    sbit[0] = 1; pbit[2] = 1; pbit[5] = 1; pbit[7] = 1; pbit[15] = 1; sbit[20] = 1;
    run_len = 22;
    run_case(4, 1, 0, 0);

    // Accumulation with an early second SYNC
    clear_stim();
    sbit[0] = 1; sbit[20] = 1; sbit[52] = 1; sbit[84] = 1;
    pbit[10] = 1; pbit[30] = 1; pbit[62] = 1;
    run_len = 86;
    run_case(8, 3, 0, 0);

    // Boundaries: edge on SYNC, on first wrap, after last bin, on final SYNC
    clear_stim();
    sbit[0] = 1; sbit[22] = 1;
    pbit[0] = 1; pbit[4] = 1; pbit[16] = 1; pbit[18] = 1; pbit[22] = 1;
    run_len = 24;
    run_case(4, 1, 0, 0);

    // PMT coincident with a non-final SYNC lands in bin 0 of the new period
    clear_stim();
    sbit[0] = 1; sbit[10] = 1; sbit[40] = 1;
    pbit[7] = 1; pbit[10] = 1;
    run_len = 42;
    run_case(4, 2, 0, 0);

    // Saturation in bin 2
    clear_stim();
    sbit[0] = 1; sbit[200] = 1;
    for (int k = 0; k < 20; k++) pbit[97 + 2 * k] = 1;
    run_len = 202;
    run_case(48, 1, 0, 0);

    // bin_div = 0 and max_count = 0 behave as 1
    clear_stim();
    sbit[0] = 1; sbit[8] = 1;
    pbit[1] = 1; pbit[3] = 1; pbit[5] = 1;
    run_len = 10;
    run_case(0, 0, 0, 0);

    // Random runs with backpressure and activity during the dump
    for (int it = 0; it < 10; it++) begin
      int bd, mc, mce, bdl, pos;
      bd  = $urandom_range(0, 6);
      mc  = $urandom_range(0, 3);
      mce = (mc == 0) ? 1 : mc;
      bdl = (bd == 0) ? 1 : bd;
      clear_stim();
      pos = 0;
      for (int p = 0; p < mce; p++) begin
        sbit[pos] = 1;
        pos += $urandom_range(3, NBINS * bdl + 6);
      end
      sbit[pos] = 1;
      run_len = pos + 2;
      for (int c = 0; c <= pos; c++)
        if (c == 0 || !pbit[c-1]) pbit[c] = ($urandom_range(0, 2) == 0);
      run_case(bd, mc, 1, 1);
    end

    // Abort mid-BIN, then an empty run must read all zeros
    clear_stim();
    sbit[0] = 1; pbit[2] = 1; pbit[5] = 1;
    run_len = 12;
    start_run(4, 2);
    drive_run();
    enable = 1'b0;
    repeat (2) tick();
    check_eq("abort_busy", busy, 0);
    check_eq("abort_ovf", overflow, 0);
    clear_stim();
    sbit[0] = 1; sbit[20] = 1;
    run_len = 22;
    run_case(4, 1, 0, 0);

    // Asynchronous reset in the middle of a stalled dump
    clear_stim();
    sbit[0] = 1; pbit[2] = 1; pbit[5] = 1; pbit[7] = 1; pbit[15] = 1; sbit[20] = 1;
    run_len = 22;
    start_run(4, 1);
    drive_run();
    waitc = 0;
    while (!rd_valid && waitc < 100) begin
      tick();
      waitc++;
    end
    check_eq("pre_rst_valid", rd_valid, 1);
    check_eq("pre_rst_data", rd_data, 1);
    rd_ready = 1'b0;
    repeat (2) tick();
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_valid", rd_valid, 0);
    check_eq("arst_data", rd_data, 0);
    check_eq("arst_bin", rd_bin, 0);
    check_eq("arst_last", rd_last, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_ovf", overflow, 0);
    enable = 1'b0;
    #2 reset_n = 1'b1;
    repeat (3) tick();
    check_eq("post_rst_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
